// File: rtl/pht_counter_table.sv
// Pattern-history table of saturating counters: one synchronous prediction port,
// one read-modify-write update port, and a one-entry-per-cycle reset sweep.
module pht_counter_table #(
  parameter int ADDR_W   = 10,
  parameter int CTR_W    = 2,
  parameter int INIT_VAL = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pred_req,
  input  logic [ADDR_W-1:0] pred_addr,
  output logic              pred_vld,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic              init_done
);

  localparam int               DEPTH     = 1 << ADDR_W;
  localparam logic [CTR_W-1:0] INIT_CTR  = CTR_W'(INIT_VAL);
  localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [ADDR_W:0]  SWEEP_END = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  PTR_ONE   = (ADDR_W+1)'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   sweep_ptr, sweep_ptr_nxt;

  logic [CTR_W-1:0]  mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CTR_W-1:0]  wr_data;

  logic              upd_acc;
  logic              u1_vld;
  logic [ADDR_W-1:0] u1_addr;
  logic              u1_taken;
  logic [CTR_W-1:0]  u1_ram;
  logic              u1_byp;
  logic [CTR_W-1:0]  u1_byp_data;
  logic [CTR_W-1:0]  u1_old;
  logic [CTR_W-1:0]  u1_new;

  logic              u2_vld;
  logic [ADDR_W-1:0] u2_addr;
  logic [CTR_W-1:0]  u2_new;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= INIT;
      sweep_ptr <= '0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_ptr_nxt;
    end
  end

  // The sweep owns the single write port in INIT; the update pipeline owns it in RUN.
  always_comb begin
    state_nxt     = state;
    sweep_ptr_nxt = sweep_ptr;
    wr_en         = 1'b0;
    wr_addr       = u2_addr;
    wr_data       = u2_new;
    case (state)
      INIT: begin
        if (sweep_ptr == SWEEP_END) begin
          state_nxt = RUN;
        end else begin
          wr_en         = 1'b1;
          wr_addr       = sweep_ptr[ADDR_W-1:0];
          wr_data       = INIT_CTR;
          sweep_ptr_nxt = sweep_ptr + PTR_ONE;
        end
      end
      RUN: begin
        wr_en = u2_vld;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign upd_ready = (state == RUN);
  assign init_done = (state == RUN);
  assign upd_acc   = upd_valid && upd_ready;

  always_ff @(posedge clk) begin
    if (wr_en && rstn) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      u1_vld <= 1'b0;
      u2_vld <= 1'b0;
    end else begin
      u1_vld <= upd_acc;
      u2_vld <= u1_vld;
    end
  end

  // Raw RAM read plus a bypass flag for a write landing on the same edge as the read.
  always_ff @(posedge clk) begin
    if (upd_acc) begin
      u1_addr     <= upd_addr;
      u1_taken    <= upd_taken;
      u1_ram      <= mem[upd_addr];
      u1_byp      <= wr_en && (wr_addr == upd_addr);
      u1_byp_data <= wr_data;
    end
    u2_addr <= u1_addr;
    u2_new  <= u1_new;
  end

  // The update one stage ahead is the most recent writer, so it wins over the bypass.
  always_comb begin
    u1_old = u1_ram;
    if (u2_vld && (u2_addr == u1_addr)) begin
      u1_old = u2_new;
    end else if (u1_byp) begin
      u1_old = u1_byp_data;
    end
    u1_new = u1_old;
    if (u1_taken) begin
      if (u1_old != CTR_MAX) u1_new = u1_old + CTR_ONE;
    end else begin
      if (u1_old != '0) u1_new = u1_old - CTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pred_vld <= 1'b0;
      pred_ctr <= INIT_CTR;
    end else begin
      pred_vld <= pred_req;
      if (pred_req) begin
        if (state == INIT) begin
          pred_ctr <= INIT_CTR;
        end else if (wr_en && (wr_addr == pred_addr)) begin
          pred_ctr <= wr_data;
        end else begin
          pred_ctr <= mem[pred_addr];
        end
      end
    end
  end

  assign pred_taken = pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_pht_counter_table.sv
// Randomized and directed bench for pht_counter_table against a queue-based table model,
// plus a small directed run of a narrow/wide-counter parameterisation.
module tb_pht_counter_table;

  localparam int ADDR_W   = 10;
  localparam int CTR_W    = 2;
  localparam int INIT_VAL = 1;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int MAXV     = (1 << CTR_W) - 1;

  localparam int B_ADDR_W = 4;
  localparam int B_CTR_W  = 3;
  localparam int B_INIT   = 3;
  localparam int B_DEPTH  = 1 << B_ADDR_W;
  localparam int B_MAXV   = (1 << B_CTR_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, pred_req, pred_vld, pred_taken;
  logic              upd_valid, upd_taken, upd_ready, init_done;
  logic [ADDR_W-1:0] pred_addr, upd_addr;
  logic [CTR_W-1:0]  pred_ctr;

  logic                b_rstn, b_pred_req, b_pred_vld, b_pred_taken;
  logic                b_upd_valid, b_upd_taken, b_upd_ready, b_init_done;
  logic [B_ADDR_W-1:0] b_pred_addr, b_upd_addr;
  logic [B_CTR_W-1:0]  b_pred_ctr;

  pht_counter_table #(.ADDR_W(ADDR_W), .CTR_W(CTR_W), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rstn(rstn),
    .pred_req(pred_req), .pred_addr(pred_addr),
    .pred_vld(pred_vld), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .init_done(init_done)
  );

  pht_counter_table #(.ADDR_W(B_ADDR_W), .CTR_W(B_CTR_W), .INIT_VAL(B_INIT)) dut_b (
    .clk(clk), .rstn(b_rstn),
    .pred_req(b_pred_req), .pred_addr(b_pred_addr),
    .pred_vld(b_pred_vld), .pred_ctr(b_pred_ctr), .pred_taken(b_pred_taken),
    .upd_valid(b_upd_valid), .upd_addr(b_upd_addr), .upd_taken(b_upd_taken),
    .upd_ready(b_upd_ready), .init_done(b_init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a plain table, updates applied two edges after acceptance, in order.
  typedef struct { int addr; int taken; int due; } upd_t;
  int   ref_ctr [DEPTH];
  upd_t pend [$];
  int   edges_up;
  int   cyc;
  int   exp_pred;
  bit   exp_vld;
  int   zero_cnt;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int sat_step(input int v, input int taken, input int maxv);
    if (taken != 0) return (v < maxv) ? v + 1 : v;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic model_edge();
    bit done_before;
    done_before = (edges_up > DEPTH);
    cyc++;
    if (!rstn) begin
      edges_up = 0;
      pend.delete();
      foreach (ref_ctr[i]) ref_ctr[i] = INIT_VAL;
      exp_vld  = 1'b0;
      exp_pred = INIT_VAL;
      return;
    end
    while (pend.size() > 0 && pend[0].due == cyc) begin
      ref_ctr[pend[0].addr] = sat_step(ref_ctr[pend[0].addr], pend[0].taken, MAXV);
      void'(pend.pop_front());
    end
    exp_vld = pred_req;
    if (pred_req) exp_pred = done_before ? ref_ctr[int'(pred_addr)] : INIT_VAL;
    if (upd_valid && done_before) pend.push_back('{int'(upd_addr), int'(upd_taken), cyc + 2});
    if (edges_up <= DEPTH) edges_up++;
  endtask

  task automatic applyStimulus(input bit rst_v, input bit preq, input int paddr,
                               input bit uvld, input int uaddr, input bit utaken);
    @(negedge clk);
    rstn      = rst_v;
    pred_req  = preq;
    pred_addr = ADDR_W'(paddr);
    upd_valid = uvld;
    upd_addr  = ADDR_W'(uaddr);
    upd_taken = utaken;
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("pred_vld", int'(pred_vld), int'(exp_vld));
    checkOutput("pred_ctr", int'(pred_ctr), exp_pred);
    checkOutput("pred_taken", int'(pred_taken), (exp_pred >> (CTR_W - 1)) & 1);
    checkOutput("init_done", int'(init_done), int'(edges_up > DEPTH));
    checkOutput("upd_ready", int'(upd_ready), int'(edges_up > DEPTH));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic predict(input int a);
    applyStimulus(1'b1, 1'b1, a, 1'b0, 0, 1'b0);
  endtask

  task automatic update(input int a, input bit t);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, a, t);
  endtask

  task automatic b_step(input bit rst_v, input bit preq, input int paddr,
                        input bit uvld, input int uaddr, input bit utaken);
    @(negedge clk);
    b_rstn      = rst_v;
    b_pred_req  = preq;
    b_pred_addr = B_ADDR_W'(paddr);
    b_upd_valid = uvld;
    b_upd_addr  = B_ADDR_W'(uaddr);
    b_upd_taken = utaken;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; pred_req = 1'b0; pred_addr = '0; upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0;
    b_rstn = 1'b0; b_pred_req = 1'b0; b_pred_addr = '0; b_upd_valid = 1'b0; b_upd_addr = '0; b_upd_taken = 1'b0;
    edges_up = 0; cyc = 0; exp_vld = 1'b0; exp_pred = INIT_VAL;
    foreach (ref_ctr[i]) ref_ctr[i] = INIT_VAL;

    $display("[TB] reset and sweep with an update to index 3 held throughout");
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    zero_cnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b1, i[0], i, 1'b1, 3, 1'b1);
      if (!init_done) zero_cnt++;
    end
    checkOutput("sweep_len", zero_cnt, DEPTH);

    $display("[TB] read back every entry");
    for (int i = 0; i < DEPTH; i++) predict(i);
    predict(3);
    checkOutput("idx3_after_init", int'(pred_ctr), INIT_VAL);

    $display("[TB] saturate up and down on index 5");
    repeat (4) update(5, 1'b1);
    idle(2);
    predict(5);
    checkOutput("sat_up_ctr", int'(pred_ctr), MAXV);
    checkOutput("sat_up_taken", int'(pred_taken), 1);
    repeat (5) update(5, 1'b0);
    idle(2);
    predict(5);
    checkOutput("sat_down_ctr", int'(pred_ctr), 0);

    $display("[TB] back-to-back forwarding on indices 7 and 9");
    repeat (3) update(7, 1'b1);
    idle(2);
    predict(7);
    checkOutput("b2b_taken", int'(pred_ctr), 3);
    for (int i = 0; i < 4; i++) update(9, (i % 2) == 0);
    idle(2);
    predict(9);
    checkOutput("b2b_alternate", int'(pred_ctr), 1);

    $display("[TB] write-first prediction on index 12");
    update(12, 1'b1);
    predict(12);
    checkOutput("wf_e1_old", int'(pred_ctr), 1);
    predict(12);
    checkOutput("wf_e2_new", int'(pred_ctr), 2);

    $display("[TB] random traffic over a small index window");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle(2);

    $display("[TB] reset in the middle of an update");
    update(20, 1'b1);
    update(20, 1'b1);
    idle(2);
    predict(20);
    checkOutput("idx20_set", int'(pred_ctr), 3);
    update(20, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("midreset_done_low", int'(init_done), 0);
    zero_cnt = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 1'b0, 0, 1'b0);
      if (!init_done) zero_cnt++;
    end
    checkOutput("resweep_len", zero_cnt, DEPTH);
    predict(20);
    checkOutput("idx20_after_reset", int'(pred_ctr), INIT_VAL);
    idle(1);

    $display("[TB] ADDR_W=4 CTR_W=3 INIT_VAL=3 instance");
    repeat (2) b_step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("b_reset_ctr", int'(b_pred_ctr), B_INIT);
    checkOutput("b_reset_vld", int'(b_pred_vld), 0);
    zero_cnt = 0;
    for (int i = 0; i < 4 * B_DEPTH && !b_init_done; i++) begin
      b_step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      if (!b_init_done) zero_cnt++;
    end
    checkOutput("b_sweep_len", zero_cnt, B_DEPTH);
    checkOutput("b_init_done", int'(b_init_done), 1);
    b_step(1'b1, 1'b1, 2, 1'b0, 0, 1'b0);
    checkOutput("b_init_ctr", int'(b_pred_ctr), B_INIT);
    checkOutput("b_init_taken", int'(b_pred_taken), 0);
    for (int k = 1; k <= 5; k++) begin
      int e;
      e = (B_INIT + k > B_MAXV) ? B_MAXV : B_INIT + k;
      b_step(1'b1, 1'b0, 0, 1'b1, 2, 1'b1);
      b_step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      b_step(1'b1, 1'b1, 2, 1'b0, 0, 1'b0);
      checkOutput("b_sat_ctr", int'(b_pred_ctr), e);
      checkOutput("b_sat_taken", int'(b_pred_taken), int'(e >= 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
